vga_timing_gen: RTL and testbench

Synthesizable VGA raster generator that drives the vga_* bus consumed by the team's VGA frame monitor and the board DAC. It owns the horizontal/vertical counters and produces sync pulses and a display-enable. It fetches each visible pixel from an upstream pixel source, such as the tetris renderer, over a fixed-latency request interface. All vga_* outputs are pipeline-aligned so that colour, colorEn and syncs change on the same edge.

---
 rtl/vga_timing_gen.sv | 213 +++++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// ============================================================================
// vga_timing_gen
//   VGA raster generator: h/v counters, pixel fetch requests and sync/colour
//   outputs aligned through a 3-stage pipeline.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module vga_timing_gen #(
   parameter int H_DISPLAY   = 640,
   parameter int H_FRONT     = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BACK      = 48,
   parameter int V_DISPLAY   = 480,
   parameter int V_FRONT     = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BACK      = 33,
   parameter bit SYNC_ACTIVE = 1'b0,
   parameter int X_W         = 10,
   parameter int Y_W         = 10
) (
   input  logic           vga_clk,
   input  logic           vga_rst,
   input  logic           en,
   output logic           pix_req,
   output logic [X_W-1:0] pix_x,
   output logic [Y_W-1:0] pix_y,
   input  logic [11:0]    pix_rgb,
   output logic           vga_hSync,
   output logic           vga_vSync,
   output logic           vga_colorEn,
   output logic [3:0]     vga_color_r,
   output logic [3:0]     vga_color_g,
   output logic [3:0]     vga_color_b,
   output logic           frame_done,
   output logic [15:0]    frame_cnt,
   output logic           busy
);

   localparam int c_h_total = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int c_v_total = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   // Window bounds carry one extra bit so an end bound equal to the total still fits.
   localparam logic [X_W-1:0] c_h_last     = X_W'(c_h_total - 1);
   localparam logic [Y_W-1:0] c_v_last     = Y_W'(c_v_total - 1);
   localparam logic [X_W:0]   c_h_disp     = (X_W+1)'(H_DISPLAY);
   localparam logic [X_W:0]   c_hs_start   = (X_W+1)'(H_DISPLAY + H_FRONT);
   localparam logic [X_W:0]   c_hs_end     = (X_W+1)'(H_DISPLAY + H_FRONT + H_SYNC);
   localparam logic [Y_W:0]   c_v_disp     = (Y_W+1)'(V_DISPLAY);
   localparam logic [Y_W:0]   c_vs_start   = (Y_W+1)'(V_DISPLAY + V_FRONT);
   localparam logic [Y_W:0]   c_vs_end     = (Y_W+1)'(V_DISPLAY + V_FRONT + V_SYNC);
   localparam logic           c_sync_on    = SYNC_ACTIVE;
   localparam logic           c_sync_off   = ~SYNC_ACTIVE;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_STOP = 2'd2
   } state_t;

   // Stage 0 state
   state_t         state_q, state_d;
   logic [X_W-1:0] h_q, h_d;
   logic [Y_W-1:0] v_q, v_d;

   // Stage 1
   logic           pix_req_q, pix_req_d;
   logic [X_W-1:0] pix_x_q, pix_x_d;
   logic [Y_W-1:0] pix_y_q, pix_y_d;
   logic           vis1_q, vis1_d;
   logic           hs1_q, hs1_d;
   logic           vs1_q, vs1_d;

   // Stage 2
   logic           vis2_q, vis2_d;
   logic           hs2_q, hs2_d;
   logic           vs2_q, vs2_d;

   // Stage 3 / outputs
   logic           color_en_q, color_en_d;
   logic [11:0]    color_q, color_d;
   logic           hsync_q, hsync_d;
   logic           vsync_q, vsync_d;
   logic           frame_done_q, frame_done_d;
   logic [15:0]    frame_cnt_q, frame_cnt_d;

   logic           w_active;
   logic           w_h_wrap;
   logic           w_v_wrap;
   logic           w_last;
   logic           w_vis0;
   logic           w_hs0;
   logic           w_vs0;

   // Stage 0 decode: idle forces blank, inactive-sync values into the pipeline.
   always_comb begin
      w_active = (state_q != ST_IDLE);
      w_h_wrap = (h_q == c_h_last);
      w_v_wrap = (v_q == c_v_last);
      w_last   = w_active && w_h_wrap && w_v_wrap;
      w_vis0   = w_active && ({1'b0, h_q} < c_h_disp) && ({1'b0, v_q} < c_v_disp);
      w_hs0    = w_active && ({1'b0, h_q} >= c_hs_start) && ({1'b0, h_q} < c_hs_end);
      w_vs0    = w_active && ({1'b0, v_q} >= c_vs_start) && ({1'b0, v_q} < c_vs_end);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (en) state_d = ST_RUN;
         ST_RUN:  if (!en) state_d = ST_STOP;
         ST_STOP: begin
            if (en) begin
               state_d = ST_RUN;
            end else if (w_last) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      h_d = '0;
      v_d = '0;
      if (w_active) begin
         h_d = w_h_wrap ? '0 : h_q + 1'b1;
         v_d = v_q;
         if (w_h_wrap) begin
            v_d = w_v_wrap ? '0 : v_q + 1'b1;
         end
      end
   end

   always_comb begin
      pix_req_d    = w_vis0;
      pix_x_d      = w_vis0 ? h_q : pix_x_q;
      pix_y_d      = w_vis0 ? v_q : pix_y_q;
      vis1_d       = w_vis0;
      hs1_d        = w_hs0;
      vs1_d        = w_vs0;

      vis2_d       = vis1_q;
      hs2_d        = hs1_q;
      vs2_d        = vs1_q;

      // pix_rgb belongs to the request issued two cycles earlier.
      color_en_d   = vis2_q;
      color_d      = vis2_q ? pix_rgb : 12'h000;
      hsync_d      = hs2_q ? c_sync_on : c_sync_off;
      vsync_d      = vs2_q ? c_sync_on : c_sync_off;

      frame_done_d = w_last;
      frame_cnt_d  = frame_cnt_q + 16'(w_last);
   end

   always_ff @(posedge vga_clk or posedge vga_rst) begin
      if (vga_rst) begin
         state_q      <= ST_IDLE;
         h_q          <= '0;
         v_q          <= '0;
         pix_req_q    <= 1'b0;
         pix_x_q      <= '0;
         pix_y_q      <= '0;
         vis1_q       <= 1'b0;
         hs1_q        <= 1'b0;
         vs1_q        <= 1'b0;
         vis2_q       <= 1'b0;
         hs2_q        <= 1'b0;
         vs2_q        <= 1'b0;
         color_en_q   <= 1'b0;
         color_q      <= 12'h000;
         hsync_q      <= c_sync_off;
         vsync_q      <= c_sync_off;
         frame_done_q <= 1'b0;
         frame_cnt_q  <= 16'h0000;
      end else begin
         state_q      <= state_d;
         h_q          <= h_d;
         v_q          <= v_d;
         pix_req_q    <= pix_req_d;
         pix_x_q      <= pix_x_d;
         pix_y_q      <= pix_y_d;
         vis1_q       <= vis1_d;
         hs1_q        <= hs1_d;
         vs1_q        <= vs1_d;
         vis2_q       <= vis2_d;
         hs2_q        <= hs2_d;
         vs2_q        <= vs2_d;
         color_en_q   <= color_en_d;
         color_q      <= color_d;
         hsync_q      <= hsync_d;
         vsync_q      <= vsync_d;
         frame_done_q <= frame_done_d;
         frame_cnt_q  <= frame_cnt_d;
      end
   end

   assign pix_req     = pix_req_q;
   assign pix_x       = pix_x_q;
   assign pix_y       = pix_y_q;
   assign vga_hSync   = hsync_q;
   assign vga_vSync   = vsync_q;
   assign vga_colorEn = color_en_q;
   assign vga_color_r = color_q[11:8];
   assign vga_color_g = color_q[7:4];
   assign vga_color_b = color_q[3:0];
   assign frame_done  = frame_done_q;
   assign frame_cnt   = frame_cnt_q;
   assign busy        = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ============================================================================
// tb_vga_timing_gen
//   Small-raster bench for vga_timing_gen with a frame-level reference model.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_vga_timing_gen;

   localparam int HD = 8, HF = 2, HS = 2, HB = 2;
   localparam int VD = 4, VF = 1, VS = 1, VB = 1;
   localparam int HT = HD + HF + HS + HB;
   localparam int VT = VD + VF + VS + VB;

   logic        vga_clk = 1'b0;
   logic        vga_rst = 1'b1;
   logic        en      = 1'b0;
   logic        pix_req;
   logic [9:0]  pix_x;
   logic [9:0]  pix_y;
   logic [11:0] pix_rgb;
   logic        vga_hSync, vga_vSync, vga_colorEn;
   logic [3:0]  vga_color_r, vga_color_g, vga_color_b;
   logic        frame_done;
   logic [15:0] frame_cnt;
   logic        busy;

   vga_timing_gen #(
      .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .SYNC_ACTIVE(1'b0), .X_W(10), .Y_W(10)
   ) dut (
      .vga_clk(vga_clk), .vga_rst(vga_rst), .en(en),
      .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
      .vga_hSync(vga_hSync), .vga_vSync(vga_vSync), .vga_colorEn(vga_colorEn),
      .vga_color_r(vga_color_r), .vga_color_g(vga_color_g), .vga_color_b(vga_color_b),
      .frame_done(frame_done), .frame_cnt(frame_cnt), .busy(busy)
   );

   always #5 vga_clk = ~vga_clk;

   // Registered pixel source: answers a request on the following cycle.
   bit src_mode = 1'b0;
   always @(posedge vga_clk) pix_rgb <= src_mode ? 12'hFFF : {pix_y[3:0], pix_x[3:0], 4'hA};

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: raster position per cycle, outputs delayed as a whole.
   typedef struct {
      bit vis;
      bit hs;
      bit vs;
      int h;
      int v;
   } snap_t;

   snap_t hist[3];
   int    m_mode, m_h, m_v, m_fcnt, m_px, m_py;
   bit    m_req, m_fdone;

   task automatic model_reset();
      m_mode = 0; m_h = 0; m_v = 0; m_fcnt = 0; m_px = 0; m_py = 0;
      m_req = 1'b0; m_fdone = 1'b0;
      foreach (hist[i]) hist[i] = '{vis: 1'b0, hs: 1'b0, vs: 1'b0, h: 0, v: 0};
   endtask

   task automatic model_edge(input bit en_s);
      snap_t s;
      bit    act, last;
      act   = (m_mode != 0);
      s.vis = act && (m_h < HD) && (m_v < VD);
      s.hs  = act && (m_h >= HD + HF) && (m_h < HD + HF + HS);
      s.vs  = act && (m_v >= VD + VF) && (m_v < VD + VF + VS);
      s.h   = m_h;
      s.v   = m_v;
      last  = act && (m_h == HT - 1) && (m_v == VT - 1);
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = s;
      m_req = s.vis;
      if (s.vis) begin
         m_px = m_h;
         m_py = m_v;
      end
      m_fdone = last;
      if (last) m_fcnt = (m_fcnt + 1) % 65536;
      case (m_mode)
         0:       m_mode = en_s ? 1 : 0;
         1:       m_mode = en_s ? 1 : 2;
         default: m_mode = en_s ? 1 : (last ? 0 : 2);
      endcase
      if (act) begin
         m_h = (m_h + 1) % HT;
         if (m_h == 0) m_v = (m_v + 1) % VT;
      end else begin
         m_h = 0;
         m_v = 0;
      end
   endtask

   function automatic logic [11:0] exp_rgb(input snap_t o);
      if (!o.vis) return 12'h000;
      if (src_mode) return 12'hFFF;
      return {4'(o.v), 4'(o.h), 4'hA};
   endfunction

   task automatic check_outputs(input string ph);
      snap_t o;
      o = hist[2];
      chk({ph, ":busy"},       busy,        32'(m_mode != 0));
      chk({ph, ":pix_req"},    pix_req,     32'(m_req));
      chk({ph, ":pix_x"},      pix_x,       m_px);
      chk({ph, ":pix_y"},      pix_y,       m_py);
      chk({ph, ":frame_done"}, frame_done,  32'(m_fdone));
      chk({ph, ":frame_cnt"},  frame_cnt,   m_fcnt);
      chk({ph, ":colorEn"},    vga_colorEn, 32'(o.vis));
      chk({ph, ":rgb"},        {vga_color_r, vga_color_g, vga_color_b}, exp_rgb(o));
      chk({ph, ":hSync"},      vga_hSync,   32'(!o.hs));
      chk({ph, ":vSync"},      vga_vSync,   32'(!o.vs));
   endtask

   task automatic step();
      @(posedge vga_clk);
      model_edge(en);
      #1;
      check_outputs("run");
      cyc++;
   endtask

   // Expects colorEn on the 4th edge after en is raised from IDLE.
   task automatic first_cen(input string tag);
      int k;
      k = 0;
      for (int i = 1; i <= 20 && k == 0; i++) begin
         step();
         if (vga_colorEn) k = i;
      end
      chk(tag, k, 4);
   endtask

   task automatic do_async_reset(input bit wait_cen);
      if (wait_cen) begin
         int ok;
         ok = 0;
         for (int i = 0; i < 200 && ok == 0; i++) begin
            step();
            if (vga_colorEn) ok = 1;
         end
         chk("rst_wait_colorEn", ok, 1);
      end
      #2 vga_rst = 1'b1;
      #1;
      model_reset();
      check_outputs("async_rst");
      repeat (2) begin
         @(posedge vga_clk);
         #1;
         check_outputs("in_rst");
      end
      vga_rst = 1'b0;
   endtask

   initial begin
      int last_fd, n_fd, cen, rise_cyc, hs_fall, vs_fall, ok;
      bit rise_ok, prev_cen, prev_hs, prev_vs;

      model_reset();
      repeat (3) @(posedge vga_clk);
      #1;
      check_outputs("reset");
      vga_rst = 1'b0;

      // Free-running raster with explicit timing measurements
      en = 1'b1;
      first_cen("first_colorEn");
      last_fd = 0; n_fd = 0; cen = 0; rise_cyc = 0; hs_fall = 0; vs_fall = 0;
      rise_ok = 1'b0; prev_cen = vga_colorEn; prev_hs = vga_hSync; prev_vs = vga_vSync;
      for (int i = 0; i < 5 * HT * VT; i++) begin
         step();
         if (vga_colorEn) cen++;
         if (vga_colorEn && !prev_cen) begin
            rise_cyc = cyc;
            rise_ok  = 1'b1;
         end
         if (!vga_hSync && prev_hs) begin
            hs_fall = cyc;
            if (rise_ok) chk("hsync_after_colorEn", cyc - rise_cyc, HD + HF);
            rise_ok = 1'b0;
         end
         if (vga_hSync && !prev_hs) chk("hsync_width", cyc - hs_fall, HS);
         if (!vga_vSync && prev_vs) vs_fall = cyc;
         if (vga_vSync && !prev_vs) chk("vsync_width", cyc - vs_fall, VS * HT);
         if (frame_done) begin
            if (n_fd > 0) begin
               chk("frame_period", cyc - last_fd, HT * VT);
               chk("colorEn_per_frame", cen, HD * VD);
            end
            n_fd++;
            last_fd = cyc;
            cen     = 0;
         end
         prev_cen = vga_colorEn;
         prev_hs  = vga_hSync;
         prev_vs  = vga_vSync;
      end
      chk("frames_seen", 32'(n_fd >= 4), 1);

      // Asynchronous reset mid-line, then restart from the origin
      do_async_reset(1'b1);
      first_cen("restart_colorEn");

      // Stop at line 2 of frame 1
      ok = 0;
      for (int i = 0; i < 400 && ok == 0; i++) begin
         step();
         if (m_fcnt == 1 && m_v == 2) ok = 1;
      end
      chk("reach_frame1_line2", ok, 1);
      en = 1'b0;
      ok = 0;
      for (int i = 0; i < 300 && ok == 0; i++) begin
         step();
         if (!busy) ok = 1;
      end
      chk("stop_reached", ok, 1);
      chk("stop_frame_cnt", frame_cnt, 2);
      repeat (10) begin
         step();
         chk("idle_colorEn", vga_colorEn, 0);
         chk("idle_syncs", {vga_hSync, vga_vSync}, 2'b11);
      end

      // Blanking with an all-ones source, plus a short en gap before frame end
      src_mode = 1'b1;
      en = 1'b1;
      ok = 0;
      for (int i = 0; i < 400 && ok == 0; i++) begin
         step();
         if (m_fcnt == 3 && m_v == 2) ok = 1;
      end
      chk("reach_gap_point", ok, 1);
      en = 1'b0;
      repeat (5) begin
         step();
         chk("gap_busy", busy, 1);
      end
      en = 1'b1;
      repeat (2 * HT * VT) step();

      // Randomised en activity with occasional resets
      en = 1'b0;
      ok = 0;
      for (int i = 0; i < 300 && ok == 0; i++) begin
         step();
         if (!busy) ok = 1;
      end
      chk("drain_before_random", ok, 1);
      src_mode = 1'b0;
      repeat (3000) begin
         if ($urandom_range(0, 39) == 0) en = ~en;
         if ($urandom_range(0, 999) == 0) do_async_reset(1'b0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
